meas_frame_sequencer: RTL and testbench

Readout scheduler for the tachometer/impulse measurement block. On each one-second strobe it snapshots the three 16-bit results (freq1, freq2, imp) and emits them as one fixed 6-word frame on a single 16-bit valid/ready stream toward the host link. It handles overruns, stalled-consumer timeout and frame sequence numbering, so the measurement path never blocks on the link.

---
 rtl/meas_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_meas_frame_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/meas_frame_sequencer.sv
`timescale 1ns/1ps
// Frame sequencer: snapshots freq1/freq2/imp on sec and streams a 6-word
// frame (HEADER, SEQ, F1, F2, IMP, SUM) over a 16-bit valid/ready link.
// Ports: clock/reset (async, active-high), sec/msec strobes, enable,
//   freq1/freq2/imp inputs, tx_data/tx_valid/tx_ready stream,
//   frame_busy, frame_cnt, overrun_cnt, abort_cnt status outputs.
module meas_frame_sequencer #(
    parameter logic [15:0] HEADER     = 16'hA55A,
    parameter int unsigned TIMEOUT_MS = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sec,
    input  logic        msec,
    input  logic        enable,
    input  logic [15:0] freq1,
    input  logic [15:0] freq2,
    input  logic [15:0] imp,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_busy,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  overrun_cnt,
    output logic [7:0]  abort_cnt
);

    typedef enum logic [2:0] {
        IDLE, CAPTURE, HDR, SEQ, F1, F2, IMP, SUM
    } state_t;

    // Abort fires on the msec that would bring the counter to TIMEOUT_MS.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_MS - 1);

    state_t      state_q;
    logic [15:0] tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic [7:0]  frame_cnt_q;
    logic [7:0]  overrun_q;
    logic [7:0]  abort_q;
    logic [15:0] sh_f1_q;
    logic [15:0] sh_f2_q;
    logic [15:0] sh_imp_q;
    logic [15:0] sum_q;
    logic [15:0] to_q;

    logic        xfer;
    logic        stalled;
    logic [15:0] seq_word;

    assign xfer     = tx_valid_q && tx_ready;
    assign stalled  = tx_valid_q && !tx_ready;
    assign seq_word = {frame_cnt_q, 8'h03};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= '0;
            abort_q     <= '0;
            sh_f1_q     <= '0;
            sh_f2_q     <= '0;
            sh_imp_q    <= '0;
            sum_q       <= '0;
            to_q        <= '0;
        end else begin
            // Any sec seen while a frame is in flight is dropped and counted.
            if (sec && state_q != IDLE && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;

            unique case (state_q)
                IDLE: begin
                    if (sec && enable) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    sh_f1_q    <= freq1;
                    sh_f2_q    <= freq2;
                    sh_imp_q   <= imp;
                    tx_data_q  <= HEADER;
                    tx_valid_q <= 1'b1;
                    sum_q      <= HEADER;
                    to_q       <= '0;
                    state_q    <= HDR;
                end
                HDR: if (xfer) begin
                    tx_data_q <= seq_word;
                    sum_q     <= sum_q + seq_word;
                    state_q   <= SEQ;
                end
                SEQ: if (xfer) begin
                    tx_data_q <= sh_f1_q;
                    sum_q     <= sum_q + sh_f1_q;
                    state_q   <= F1;
                end
                F1: if (xfer) begin
                    tx_data_q <= sh_f2_q;
                    sum_q     <= sum_q + sh_f2_q;
                    state_q   <= F2;
                end
                F2: if (xfer) begin
                    tx_data_q <= sh_imp_q;
                    sum_q     <= sum_q + sh_imp_q;
                    state_q   <= IMP;
                end
                IMP: if (xfer) begin
                    // Sum already includes IMP, added when IMP was loaded.
                    tx_data_q <= sum_q;
                    state_q   <= SUM;
                end
                SUM: if (xfer) begin
                    tx_valid_q  <= 1'b0;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase

            // Word timeout; a transfer implies tx_ready=1, so it never
            // coincides with a stalled msec and always wins.
            if (xfer) begin
                to_q <= '0;
            end else if (stalled && msec) begin
                if (to_q == TO_LAST) begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                    to_q       <= '0;
                    if (abort_q != 8'hFF)
                        abort_q <= abort_q + 8'd1;
                end else begin
                    to_q <= to_q + 16'd1;
                end
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign frame_busy  = busy_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_q;
    assign abort_cnt   = abort_q;

endmodule

// File: tb/tb_meas_frame_sequencer.sv
`timescale 1ns/1ps
// Directed bench for meas_frame_sequencer: frame contents, backpressure,
// overrun, timeout, counter wrap, disable and async reset.
module tb_meas_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        sec;
    logic        msec;
    logic        enable;
    logic [15:0] freq1;
    logic [15:0] freq2;
    logic [15:0] imp;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_busy;
    logic [7:0]  frame_cnt;
    logic [7:0]  overrun_cnt;
    logic [7:0]  abort_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_fc = 8'd0;

    always #5 clock = ~clock;

    meas_frame_sequencer #(
        .HEADER    (16'hA55A),
        .TIMEOUT_MS(3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sec        (sec),
        .msec       (msec),
        .enable     (enable),
        .freq1      (freq1),
        .freq2      (freq2),
        .imp        (imp),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_busy (frame_busy),
        .frame_cnt  (frame_cnt),
        .overrun_cnt(overrun_cnt),
        .abort_cnt  (abort_cnt)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full frame; optionally stall on word stall_idx for stall_n
    // cycles, with an overrun sec (and changed inputs) on the first one.
    task automatic do_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input int stall_idx,
                            input int stall_n, input bit ovr);
        logic [15:0] w [6];
        w[0] = 16'hA55A;
        w[1] = {exp_fc, 8'h03};
        w[2] = a;
        w[3] = b;
        w[4] = c;
        w[5] = w[0] + w[1] + w[2] + w[3] + w[4];
        freq1 = a; freq2 = b; imp = c;
        enable = 1'b1; tx_ready = 1'b1; sec = 1'b1;
        tick;
        sec = 1'b0;
        chk("cap_busy", 32'(frame_busy), 32'd1);
        chk("cap_valid", 32'(tx_valid), 32'd0);
        tick;
        for (int i = 0; i < 6; i++) begin
            chk("word_valid", 32'(tx_valid), 32'd1);
            chk($sformatf("word%0d", i), 32'(tx_data), 32'(w[i]));
            if (i == stall_idx) begin
                tx_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    if (ovr && k == 0) begin
                        sec = 1'b1;
                        freq1 = ~a; freq2 = ~b; imp = ~c;
                    end
                    tick;
                    sec = 1'b0;
                    chk("stall_valid", 32'(tx_valid), 32'd1);
                    chk("stall_data", 32'(tx_data), 32'(w[i]));
                end
                tx_ready = 1'b1;
            end
            tick;
        end
        exp_fc = exp_fc + 8'd1;
        chk("end_valid", 32'(tx_valid), 32'd0);
        chk("end_busy", 32'(frame_busy), 32'd0);
        chk("end_fc", 32'(frame_cnt), 32'(exp_fc));
    endtask

    initial begin
        reset = 1'b1; sec = 1'b0; msec = 1'b0; enable = 1'b1;
        tx_ready = 1'b0; freq1 = '0; freq2 = '0; imp = '0;
        tick;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_fc", 32'(frame_cnt), 32'd0);
        chk("rst_ovr", 32'(overrun_cnt), 32'd0);
        chk("rst_abort", 32'(abort_cnt), 32'd0);
        reset = 1'b0;
        tick;

        // Timeout: 3 msec pulses while HDR is stalled.
        freq1 = 16'h1111; sec = 1'b1;
        tick;
        sec = 1'b0;
        tick;
        chk("to_hdr_valid", 32'(tx_valid), 32'd1);
        chk("to_hdr_data", 32'(tx_data), 32'h0000A55A);
        for (int p = 0; p < 3; p++) begin
            msec = 1'b1;
            tick;
            msec = 1'b0;
            if (p < 2) chk("to_pending", 32'(tx_valid), 32'd1);
            tick;
        end
        chk("to_valid", 32'(tx_valid), 32'd0);
        chk("to_abort", 32'(abort_cnt), 32'd1);
        chk("to_fc", 32'(frame_cnt), 32'd0);
        chk("to_busy", 32'(frame_busy), 32'd0);

        // Basic frame right after the abort; SEQ is still 0003.
        do_frame(16'h1234, 16'h0010, 16'h0005, -1, 0, 1'b0);

        // Backpressure on F2 for 5 cycles.
        do_frame(16'h1234, 16'h0010, 16'h0005, 3, 5, 1'b0);
        chk("bp_abort", 32'(abort_cnt), 32'd1);

        // Overrun sec while stalled on F1; shadows must not reload.
        do_frame(16'hBEEF, 16'hFFFF, 16'h8001, 2, 3, 1'b1);
        chk("ovr_cnt", 32'(overrun_cnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("ovr_no_frame", 32'(tx_valid), 32'd0);
        end
        chk("ovr_fc", 32'(frame_cnt), 32'd3);

        // Run to 256 frames; last SEQ word is FF03 and the count wraps.
        for (int n = 3; n < 256; n++)
            do_frame(16'(n), 16'(n * 7), 16'hF0F0, -1, 0, 1'b0);
        chk("wrap_fc", 32'(frame_cnt), 32'd0);

        // Disabled: sec does nothing, no overrun.
        enable = 1'b0; sec = 1'b1;
        tick;
        sec = 1'b0;
        chk("dis_busy", 32'(frame_busy), 32'd0);
        tick;
        chk("dis_valid", 32'(tx_valid), 32'd0);
        chk("dis_ovr", 32'(overrun_cnt), 32'd1);
        enable = 1'b1;

        // Async reset while SEQ is presented.
        tx_ready = 1'b1; sec = 1'b1;
        tick;
        sec = 1'b0;
        tick;
        tick;
        tx_ready = 1'b0;
        chk("rs_seq", 32'(tx_data), 32'h00000003);
        #2 reset = 1'b1;
        #1;
        chk("rs_valid", 32'(tx_valid), 32'd0);
        chk("rs_data", 32'(tx_data), 32'd0);
        chk("rs_busy", 32'(frame_busy), 32'd0);
        chk("rs_ovr", 32'(overrun_cnt), 32'd0);
        chk("rs_abort", 32'(abort_cnt), 32'd0);
        tick;
        reset = 1'b0;
        exp_fc = 8'd0;
        tick;
        do_frame(16'h00AA, 16'h0BB0, 16'hC000, -1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
